// File: rtl/rx_frame_check.sv
// UART RX frame checker: assembles strobed data bits LSB-first, checks parity and
// one or two stop bits, flags break frames and keeps saturating error counters.
module rx_frame_check #(
  parameter int DATA_WIDTH     = 8,
  parameter int STOP_BIT_VALUE = 1,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     frame_start,
  input  logic                     sampled_bit,
  input  logic                     bit_valid,
  input  logic                     par_en,
  input  logic                     par_typ,
  input  logic                     stp_two,
  input  logic                     err_clr,
  output logic [DATA_WIDTH-1:0]    p_data,
  output logic                     data_valid,
  output logic                     frame_done,
  output logic                     par_err,
  output logic                     stp_err,
  output logic                     brk_det,
  output logic [ERR_CNT_WIDTH-1:0] par_err_cnt,
  output logic [ERR_CNT_WIDTH-1:0] stp_err_cnt
);

  localparam int   IW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic STOP_LVL = 1'(STOP_BIT_VALUE);

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP1, STOP2} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [IW-1:0]         idx;
  logic                  run_par;
  logic                  par_en_q, par_typ_q, stp_two_q;
  logic                  perr_q, serr1_q, pbit_q;

  logic serr_now, serr1_f, serr2_f, last_stop, complete, brk_now;

  // Stop results for the completing edge: STOP1 may be sampled on this very edge.
  always_comb begin
    serr_now  = (sampled_bit != STOP_LVL);
    serr1_f   = (state == STOP1) ? serr_now : serr1_q;
    serr2_f   = (state == STOP2) ? serr_now : 1'b0;
    last_stop = bit_valid && ((state == STOP1 && !stp_two_q) || state == STOP2);
    complete  = last_stop && !frame_start;
    brk_now   = (shreg == '0) && !pbit_q && serr1_f;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      shreg      <= '0;
      idx        <= '0;
      run_par    <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stp_two_q  <= 1'b0;
      perr_q     <= 1'b0;
      serr1_q    <= 1'b0;
      pbit_q     <= 1'b0;
      p_data     <= '0;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      brk_det    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      brk_det    <= 1'b0;
      if (frame_start) begin
        par_en_q  <= par_en;
        par_typ_q <= par_typ;
        stp_two_q <= stp_two;
        shreg     <= '0;
        idx       <= '0;
        run_par   <= 1'b0;
        perr_q    <= 1'b0;
        serr1_q   <= 1'b0;
        pbit_q    <= 1'b0;
        state     <= DATA;
      end else if (bit_valid) begin
        case (state)
          DATA: begin
            shreg[idx] <= sampled_bit;
            run_par    <= run_par ^ sampled_bit;
            if (idx == IW'(DATA_WIDTH - 1)) begin
              idx   <= '0;
              state <= par_en_q ? PARITY : STOP1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          PARITY: begin
            perr_q <= (sampled_bit != (run_par ^ par_typ_q));
            pbit_q <= sampled_bit;
            state  <= STOP1;
          end
          STOP1: begin
            serr1_q <= serr_now;
            if (stp_two_q) state <= STOP2;
          end
          default: ;
        endcase
        if (last_stop) begin
          p_data     <= shreg;
          par_err    <= perr_q;
          stp_err    <= serr1_f | serr2_f;
          frame_done <= 1'b1;
          data_valid <= !(perr_q | serr1_f | serr2_f);
          brk_det    <= brk_now;
          state      <= IDLE;
        end
      end
    end
  end

  // Break frames are reported but never counted; clear beats increment.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
    end else if (err_clr) begin
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
    end else if (complete && !brk_now) begin
      if (perr_q && par_err_cnt != '1)
        par_err_cnt <= par_err_cnt + 1'b1;
      if ((serr1_f | serr2_f) && stp_err_cnt != '1)
        stp_err_cnt <= stp_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_frame_check.sv
// Scoreboard bench for rx_frame_check: stimulus pushes hand-computed frame results,
// a negedge monitor pops and compares on every frame_done.
module tb_rx_frame_check;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       frame_start = 1'b0, sampled_bit = 1'b0, bit_valid = 1'b0;
  logic       par_en = 1'b0, par_typ = 1'b0, stp_two = 1'b0, err_clr = 1'b0;
  logic [7:0] p_data;
  logic       data_valid, frame_done, par_err, stp_err, brk_det;
  logic [1:0] par_err_cnt, stp_err_cnt;

  typedef struct packed {
    logic [7:0] data;
    logic       pe, se, dv, brk;
    logic [1:0] pc, sc;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0, pushed = 0, popped = 0;

  rx_frame_check #(.DATA_WIDTH(8), .STOP_BIT_VALUE(1), .ERR_CNT_WIDTH(2)) dut (
    .CLK(CLK), .RST(RST), .frame_start(frame_start), .sampled_bit(sampled_bit),
    .bit_valid(bit_valid), .par_en(par_en), .par_typ(par_typ), .stp_two(stp_two),
    .err_clr(err_clr), .p_data(p_data), .data_valid(data_valid), .frame_done(frame_done),
    .par_err(par_err), .stp_err(stp_err), .brk_det(brk_det),
    .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic pe, se, dv, brk,
                              input logic [1:0] pc, sc);
    exp_t e;
    e.data = d; e.pe = pe; e.se = se; e.dv = dv; e.brk = brk; e.pc = pc; e.sc = sc;
    return e;
  endfunction

  always @(negedge CLK) begin
    if (RST && frame_done) begin
      if (q.size() == 0) begin
        chk("unexpected_frame_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        popped++;
        chk("p_data", 32'(p_data), 32'(e.data));
        chk("par_err", 32'(par_err), 32'(e.pe));
        chk("stp_err", 32'(stp_err), 32'(e.se));
        chk("data_valid", 32'(data_valid), 32'(e.dv));
        chk("brk_det", 32'(brk_det), 32'(e.brk));
        chk("par_err_cnt", 32'(par_err_cnt), 32'(e.pc));
        chk("stp_err_cnt", 32'(stp_err_cnt), 32'(e.sc));
      end
    end else if (RST && (data_valid || brk_det)) begin
      chk("pulse_without_frame_done", {data_valid, brk_det}, 32'd0);
    end
  end

  task automatic pulse_start(input logic pe, pt, st2);
    frame_start = 1'b1; par_en = pe; par_typ = pt; stp_two = st2;
    @(posedge CLK); #1;
    frame_start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1; sampled_bit = b;
    @(posedge CLK); #1;
    bit_valid = 1'b0;
  endtask

  // Expected result is pushed just before the completing bit, so an early frame_done misses.
  task automatic send_frame(input logic [7:0] d, input logic pe, pt, pb, st2, s1, s2, clr,
                            input exp_t e);
    pulse_start(pe, pt, st2);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pe) send_bit(pb);
    if (st2) send_bit(s1);
    q.push_back(e); pushed++;
    err_clr = clr;
    send_bit(st2 ? s2 : s1);
    err_clr = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_p_data"}, 32'(p_data), 32'd0);
    chk({tag, "_flags"}, {data_valid, frame_done, par_err, stp_err, brk_det}, 32'd0);
    chk({tag, "_cnts"}, {par_err_cnt, stp_err_cnt}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk_all_zero("reset");
    RST = 1'b1;
    @(posedge CLK); #1;

    // data, pe, pt, pbit, two, s1, s2, clr, expected
    send_frame(8'hA5, 1, 0, 0, 0, 1, 0, 0, mk(8'hA5, 0, 0, 1, 0, 2'd0, 2'd0));
    send_frame(8'hA5, 1, 0, 1, 0, 1, 0, 0, mk(8'hA5, 1, 0, 0, 0, 2'd1, 2'd0));
    send_frame(8'h0F, 1, 1, 1, 1, 1, 0, 0, mk(8'h0F, 0, 1, 0, 0, 2'd1, 2'd1));
    send_frame(8'h00, 1, 0, 0, 0, 0, 0, 0, mk(8'h00, 0, 1, 0, 1, 2'd1, 2'd1));
    send_frame(8'h00, 0, 0, 0, 0, 0, 0, 0, mk(8'h00, 0, 1, 0, 1, 2'd1, 2'd1));
    send_frame(8'hA5, 1, 0, 1, 0, 1, 0, 0, mk(8'hA5, 1, 0, 0, 0, 2'd2, 2'd1));
    send_frame(8'hA5, 1, 0, 1, 0, 1, 0, 0, mk(8'hA5, 1, 0, 0, 0, 2'd3, 2'd1));
    send_frame(8'hA5, 1, 0, 1, 0, 1, 0, 0, mk(8'hA5, 1, 0, 0, 0, 2'd3, 2'd1));
    send_frame(8'hA5, 1, 0, 1, 0, 1, 0, 1, mk(8'hA5, 1, 0, 0, 0, 2'd0, 2'd0));
    send_frame(8'h55, 0, 0, 0, 0, 0, 0, 0, mk(8'h55, 0, 1, 0, 0, 2'd0, 2'd1));

    // Aborted partial frame produces nothing; config changes mid-frame are ignored.
    pulse_start(1, 0, 1);
    send_bit(1); send_bit(0); send_bit(1);
    q.push_back(mk(8'h3C, 0, 0, 1, 0, 2'd0, 2'd1)); pushed++;
    pulse_start(0, 0, 0);
    par_en = 1'b1; stp_two = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(i inside {2, 3, 4, 5});
    send_bit(1);
    @(posedge CLK); #1;

    // Reset in the middle of a frame, then a clean frame.
    pulse_start(1, 0, 0);
    repeat (4) send_bit(1);
    RST = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    send_frame(8'h81, 1, 0, 0, 0, 1, 0, 0, mk(8'h81, 0, 0, 1, 0, 2'd0, 2'd0));

    repeat (3) @(posedge CLK);
    #1;
    chk("frames_completed", 32'(popped), 32'(pushed));
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
